// File: rtl/gesture_servo_driver.sv
// Gesture-controlled four-servo arm driver: maps a finger count to a pose,
// slews each joint toward it once per PWM frame and generates 50 Hz servo pulses.
module gesture_servo_driver #(
    parameter int CLK_HZ   = 100_000_000,
    parameter int FRAME_US = 20000,
    parameter int STEP_US  = 50
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] stable_count,
    input  logic       arm_enable,
    output logic [3:0] servo_pwm,
    output logic       frame_start,
    output logic [2:0] pose_idx,
    output logic       at_target
);

    localparam int               US_DIV    = CLK_HZ / 1_000_000;
    localparam int               PW        = $clog2(US_DIV);
    localparam logic [PW-1:0]    PRESC_MAX = PW'(US_DIV - 1);
    localparam logic [14:0]      FRAME_MAX = 15'(FRAME_US - 1);
    localparam logic [11:0]      STEP      = 12'(STEP_US);
    localparam logic [11:0]      HOME      = 12'd1500;

    logic [PW-1:0]     presc_q, presc_d;
    logic [14:0]       us_cnt_q, us_cnt_d;
    logic              us_tick, boundary;
    logic [3:0][11:0]  pos_q, pos_d, tgt;
    logic [2:0]        pose_q, pose_d, sel;
    logic              at_target_q, at_target_d;
    logic              frame_start_q;
    logic [3:0]        pwm_q, pwm_d;

    // Joint order within a pose word: [0]=base [1]=shoulder [2]=elbow [3]=gripper.
    function automatic logic [3:0][11:0] poseTable(input logic [2:0] idx);
        logic [3:0][11:0] w;
        w = {4{HOME}};
        case (idx)
            3'd1: w[0] = 12'd1000;
            3'd2: w[0] = 12'd2000;
            3'd3: begin w[1] = 12'd1000; w[2] = 12'd2000; end
            3'd4: begin w[1] = 12'd2000; w[2] = 12'd1000; end
            3'd5: w[3] = 12'd2200;
            default: ;
        endcase
        return w;
    endfunction

    always_comb begin
        us_tick  = (presc_q == PRESC_MAX);
        presc_d  = us_tick ? '0 : presc_q + 1'b1;
        us_cnt_d = us_cnt_q;
        if (us_tick) begin
            us_cnt_d = (us_cnt_q == FRAME_MAX) ? '0 : us_cnt_q + 1'b1;
        end
        boundary = us_tick && (us_cnt_q == FRAME_MAX);

        // An invalid count keeps steering toward the pose already latched.
        sel = (stable_count <= 3'd5) ? stable_count : pose_q;
        tgt = poseTable(sel);

        pos_d       = pos_q;
        pose_d      = pose_q;
        at_target_d = at_target_q;
        if (boundary && arm_enable) begin
            pose_d = sel;
            for (int i = 0; i < 4; i++) begin
                if (tgt[i] > pos_q[i]) begin
                    pos_d[i] = ((tgt[i] - pos_q[i]) <= STEP) ? tgt[i] : pos_q[i] + STEP;
                end else begin
                    pos_d[i] = ((pos_q[i] - tgt[i]) <= STEP) ? tgt[i] : pos_q[i] - STEP;
                end
            end
            at_target_d = (pos_d == tgt);
        end

        for (int i = 0; i < 4; i++) begin
            pwm_d[i] = arm_enable && (us_cnt_q < {3'b000, pos_q[i]});
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q       <= '0;
            us_cnt_q      <= '0;
            pos_q         <= {4{HOME}};
            pose_q        <= 3'd0;
            at_target_q   <= 1'b1;
            frame_start_q <= 1'b0;
            pwm_q         <= 4'b0000;
        end else begin
            presc_q       <= presc_d;
            us_cnt_q      <= us_cnt_d;
            pos_q         <= pos_d;
            pose_q        <= pose_d;
            at_target_q   <= at_target_d;
            frame_start_q <= boundary;
            pwm_q         <= pwm_d;
        end
    end

    assign servo_pwm   = pwm_q;
    assign frame_start = frame_start_q;
    assign pose_idx    = pose_q;
    assign at_target   = at_target_q;

endmodule

// File: tb/tb_gesture_servo_driver.sv
// Directed bench for gesture_servo_driver: measures pulse widths per frame
// and checks pose tracking, invalid-count hold, glitch rejection, disable and reset.
module tb_gesture_servo_driver;

    logic       clk;
    logic       rst_n;
    logic [2:0] stable_count;
    logic       arm_enable;
    logic [3:0] servo_pwm;
    logic       frame_start;
    logic [2:0] pose_idx;
    logic       at_target;

    int checks   = 0;
    int failures = 0;
    int measPeriod;
    int measW[4];

    gesture_servo_driver #(
        .CLK_HZ  (2_000_000),
        .FRAME_US(3000),
        .STEP_US (50)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stable_count(stable_count),
        .arm_enable  (arm_enable),
        .servo_pwm   (servo_pwm),
        .frame_start (frame_start),
        .pose_idx    (pose_idx),
        .at_target   (at_target)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [2:0] cnt, input logic en);
        stable_count = cnt;
        arm_enable   = en;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic syncFrame(input string tag);
        int n = 0;
        while (frame_start !== 1'b1 && n < 7000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 7000) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    // Called on a frame_start cycle; returns on the next one.
    task automatic measureFrame();
        measPeriod = 0;
        for (int i = 0; i < 4; i++) measW[i] = 0;
        do begin
            for (int i = 0; i < 4; i++) measW[i] += int'(servo_pwm[i]);
            measPeriod++;
            @(negedge clk);
        end while (frame_start !== 1'b1 && measPeriod < 7000);
    endtask

    task automatic checkFrame(input string tag, input int b, input int s, input int e, input int g);
        checkOutput({tag, "_period"},   measPeriod, 6000);
        checkOutput({tag, "_base"},     measW[0], b);
        checkOutput({tag, "_shoulder"}, measW[1], s);
        checkOutput({tag, "_elbow"},    measW[2], e);
        checkOutput({tag, "_gripper"},  measW[3], g);
    endtask

    initial begin
        clk   = 1'b0;
        rst_n = 1'b0;
        applyStimulus(3'd0, 1'b1);
        repeat (3) @(negedge clk);
        checkOutput("rst_pwm",   servo_pwm, 0);
        checkOutput("rst_fs",    frame_start, 0);
        checkOutput("rst_pose",  pose_idx, 0);
        checkOutput("rst_atTgt", at_target, 1);
        rst_n = 1'b1;

        syncFrame("first");
        checkOutput("e1_pose",  pose_idx, 0);
        checkOutput("e1_atTgt", at_target, 1);
        applyStimulus(3'd1, 1'b1);
        measureFrame();
        checkFrame("home", 3000, 3000, 3000, 3000);

        checkOutput("e2_pose",  pose_idx, 1);
        checkOutput("e2_atTgt", at_target, 0);
        applyStimulus(3'd7, 1'b1);
        measureFrame();
        checkFrame("base1450", 2900, 3000, 3000, 3000);

        checkOutput("e3_invalidHold", pose_idx, 1);
        measureFrame();
        checkFrame("base1400", 2800, 3000, 3000, 3000);

        checkOutput("e4_pose", pose_idx, 1);
        applyStimulus(3'd0, 1'b1);
        fork
            measureFrame();
            begin
                repeat (1000) @(negedge clk);
                applyStimulus(3'd2, 1'b1);
                repeat (100) @(negedge clk);
                applyStimulus(3'd0, 1'b1);
            end
        join
        checkFrame("base1350", 2700, 3000, 3000, 3000);

        checkOutput("e5_glitchIgnored", pose_idx, 0);
        measureFrame();
        checkFrame("back1400", 2800, 3000, 3000, 3000);

        checkOutput("e6_pose",  pose_idx, 0);
        checkOutput("e6_atTgt", at_target, 0);
        repeat (500) @(negedge clk);
        checkOutput("preDisable_pwm", servo_pwm, 4'hf);
        applyStimulus(3'd0, 1'b0);
        @(negedge clk);
        checkOutput("disable_pwm", servo_pwm, 0);
        syncFrame("disabled");
        checkOutput("e7_frozenPose",  pose_idx, 0);
        checkOutput("e7_frozenAtTgt", at_target, 0);
        measureFrame();
        checkFrame("disabled", 0, 0, 0, 0);

        applyStimulus(3'd0, 1'b1);
        measureFrame();
        checkFrame("resume1450", 2900, 3000, 3000, 3000);

        checkOutput("e9_atTgt", at_target, 1);
        checkOutput("e9_pose",  pose_idx, 0);
        applyStimulus(3'd3, 1'b1);
        measureFrame();
        checkFrame("home2", 3000, 3000, 3000, 3000);

        checkOutput("e10_pose",  pose_idx, 3);
        checkOutput("e10_atTgt", at_target, 0);
        measureFrame();
        checkFrame("pose3step", 3000, 2900, 3100, 3000);

        repeat (200) @(negedge clk);
        checkOutput("midPulse_pwm", servo_pwm, 4'hf);
        applyStimulus(3'd0, 1'b1);
        rst_n = 1'b0;
        #1;
        checkOutput("asyncRst_pwm",   servo_pwm, 0);
        checkOutput("asyncRst_fs",    frame_start, 0);
        checkOutput("asyncRst_pose",  pose_idx, 0);
        checkOutput("asyncRst_atTgt", at_target, 1);
        @(negedge clk);
        rst_n = 1'b1;
        syncFrame("postReset");
        measureFrame();
        checkFrame("postReset", 3000, 3000, 3000, 3000);
        checkOutput("postReset_atTgt", at_target, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
